fnv_unmap: RTL

- Sequential inverse of the FNV map operation on the execution-environment word store.
- For i in [0, length): reads r = mem[origin+i] and b = mem[modifier+i], then writes mem[origin+i] = (r ^ b) * FNV_PRIME_INV mod 2^32.
- FNV_PRIME_INV = 0x359C449B, the multiplicative inverse of 0x01000193 mod 2^32. The block therefore exactly undoes a prior FNV map with the same operands.
- Sits beside the operation executors as a memory-port master. The sequencer drives it with a start/done command handshake; the conditional flag is pre-evaluated by the sequencer.

---
 rtl/fnv_unmap_if.sv | 48 ++++
 rtl/fnv_unmap.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fnv_unmap_if.sv
// -----------------------------------------------------------------------------
// fnv_unmap_if
//   Bundles the command handshake from the sequencer and the word-store memory
//   port used by fnv_unmap.
//
//   Command side : start, origin, modifier, length, cond_ok -> busy, done,
//                  err, skipped
//   Memory side  : mem_req, mem_we, mem_addr, mem_wdata -> mem_gnt,
//                  mem_rvalid, mem_rdata
//
//   modport master : the fnv_unmap block (memory-port master)
//   modport slave  : the environment (sequencer plus word store)
// -----------------------------------------------------------------------------
interface fnv_unmap_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] origin;
   logic [ADDR_W-1:0] modifier;
   logic [ADDR_W:0]   length;
   logic              cond_ok;
   logic              busy;
   logic              done;
   logic              err;
   logic              skipped;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      input  start, origin, modifier, length, cond_ok,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output busy, done, err, skipped,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output start, origin, modifier, length, cond_ok,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  busy, done, err, skipped,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/fnv_unmap.sv
// -----------------------------------------------------------------------------
// fnv_unmap
//   Sequential inverse of the FNV map on the word store. For each i in
//   [0, length) it reads r = mem[origin+i] and b = mem[modifier+i], then writes
//   mem[origin+i] = (r ^ b) * 0x359C449B (mod 2^32). 0x359C449B is the
//   multiplicative inverse of the FNV prime 0x01000193, so this exactly undoes
//   a prior FNV map with the same operands.
//
//   Ports
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : fnv_unmap_if.master (command handshake + memory port)
// -----------------------------------------------------------------------------
module fnv_unmap #(
   parameter int ADDR_W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   fnv_unmap_if.master  bus
);

   localparam logic [31:0]       FNV_PRIME_INV = 32'h359C449B;
   // DEPTH widened by one bit so origin+length can be compared without wrap.
   localparam logic [ADDR_W+1:0] DEPTH_X       = {2'b01, {ADDR_W{1'b0}}};

   typedef enum logic [3:0] {
      IDLE, CHECK, RD_R, WT_R, RD_B, WT_B, EXEC, WR, DONE
   } state_t;

   state_t            state_q, state_d;
   logic              err_q, err_d;
   logic              skip_q, skip_d;

   logic [ADDR_W-1:0] orig_q, orig_d;
   logic [ADDR_W-1:0] mod_q, mod_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic              cond_q, cond_d;
   logic [31:0]       r_q, r_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       res_q, res_d;

   logic [ADDR_W+1:0] o_end, m_end;
   logic              out_of_range;
   logic              overlap;
   logic [ADDR_W-1:0] addr_r, addr_b;
   logic [ADDR_W:0]   idx_nxt;

   function automatic logic [31:0] unmap_word(input logic [31:0] r,
                                              input logic [31:0] b);
      return (r ^ b) * FNV_PRIME_INV;
   endfunction

   // Range ends are exclusive; computed one bit wider so no address wraps.
   assign o_end        = {2'b00, orig_q} + {1'b0, len_q};
   assign m_end        = {2'b00, mod_q}  + {1'b0, len_q};
   assign out_of_range = (o_end > DEPTH_X) || (m_end > DEPTH_X);
   assign overlap      = ({2'b00, orig_q} < m_end) && ({2'b00, mod_q} < o_end);

   // In-range indices never exceed DEPTH-1, so truncating the index is safe.
   assign addr_r  = orig_q + idx_q[ADDR_W-1:0];
   assign addr_b  = mod_q  + idx_q[ADDR_W-1:0];
   assign idx_nxt = idx_q + {{ADDR_W{1'b0}}, 1'b1};

   always_comb begin
      state_d       = state_q;
      err_d         = err_q;
      skip_d        = skip_q;
      orig_d        = orig_q;
      mod_d         = mod_q;
      len_d         = len_q;
      idx_d         = idx_q;
      cond_d        = cond_q;
      r_d           = r_q;
      b_d           = b_q;
      res_d         = res_q;

      bus.busy      = (state_q != IDLE);
      bus.done      = 1'b0;
      bus.err       = err_q;
      bus.skipped   = skip_q;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               orig_d  = bus.origin;
               mod_d   = bus.modifier;
               len_d   = bus.length;
               cond_d  = bus.cond_ok;
               err_d   = 1'b0;
               skip_d  = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (!cond_q) begin
               skip_d  = 1'b1;
               state_d = DONE;
            end else if (len_q == '0) begin
               state_d = DONE;
            end else if (out_of_range || overlap) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               idx_d   = '0;
               state_d = RD_R;
            end
         end
         RD_R: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = addr_r;
            if (bus.mem_gnt) state_d = WT_R;
         end
         WT_R: begin
            if (bus.mem_rvalid) begin
               r_d     = bus.mem_rdata;
               state_d = RD_B;
            end
         end
         RD_B: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = addr_b;
            if (bus.mem_gnt) state_d = WT_B;
         end
         WT_B: begin
            if (bus.mem_rvalid) begin
               b_d     = bus.mem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_d   = unmap_word(r_q, b_q);
            state_d = WR;
         end
         WR: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = addr_r;
            bus.mem_wdata = res_q;
            if (bus.mem_gnt) begin
               if (idx_nxt < len_q) begin
                  idx_d   = idx_nxt;
                  state_d = RD_R;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state: asynchronously reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         skip_q  <= skip_d;
      end
   end

   // Command fields and datapath: always written before being used
   always_ff @(posedge clk) begin
      orig_q <= orig_d;
      mod_q  <= mod_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      cond_q <= cond_d;
      r_q    <= r_d;
      b_q    <= b_d;
      res_q  <= res_d;
   end

endmodule
